mux_n_stream: RTL and testbench
===============================

// Module: mux_n_stream
// PURPOSE
//  Registered, parametrised N:1 multiplexer for W-bit data streams; successor to the 2:1 mux cell.
//  Selects one of N valid/ack input channels by external select or by round-robin.
//  Drives one registered output stage with a valid/ready handshake toward the consumer.
//  Sits between multi-source datapaths and a single downstream sink.
// PARAMETERS
//  W     8   data width per channel (>=1)
//  N     4   number of input channels (2..16)
//  SW    $clog2(N)  select width (derived, not overridden)
//  MODE  0   0 = select from S; 1 = round-robin over VLD
// PORTS
//  CLK   in   1      clock, rising edge
//  RST   in   1      asynchronous reset, active-high
//  IN    in   N*W    channel data; channel i occupies IN[i*W +: W]
//  VLD   in   N      per-channel valid
//  ACK   out  N      per-channel accept; one-hot or zero, combinational
//  S     in   SW     channel select (MODE 0 only, ignored in MODE 1)
//  Q     out  W      registered output data
//  QV    out  1      output valid
//  QR    in   1      downstream ready
// BEHAVIOUR
//  - One clock (CLK); reset is asynchronous and active-high (RST).
//  - Reset: Q=0, QV=0, round-robin pointer PTR=0; ACK=0 while RST=1.
//  - Load enable: LD = !QV | QR. Output beat completes when QV & QR.
//  - Selected channel c:
//    - MODE 0: c=S; if S>=N, nothing is selected.
//    - MODE 1: first i with VLD[i]=1, scanning from PTR upward modulo N.
//  - Transfer: ACK[c]=1 iff LD & VLD[c] & c selected. On that edge: Q<=IN[c], QV<=1.
//    In MODE 1, PTR<=(c+1) mod N on the same edge.
//  - If LD=1 and no transfer, QV<=0 on the edge; Q holds its last value.
//  - Latency: input accept -> Q/QV valid on the next rising edge.
//    Throughput: 1 beat per cycle while QR=1.
//  - Stall (QV=1, QR=0): Q and QV hold; ACK=0; PTR holds; S changes have no effect until LD.
//  - Simultaneous consume and load (QV=1, QR=1, transfer): new data replaces the old in one edge, no bubble.
//  - Wrap-around: PTR=N-1 with a grant to N-1 -> PTR=0.
//  - Data stability: IN[c] is sampled only on the ACK cycle. Sources hold IN/VLD until ACK.
//  - RST mid-operation: held beat is discarded, QV=0 immediately (async), PTR=0.
//    First accept happens on the first edge after RST deasserts.
//  - QV never depends combinationally on QR. ACK depends on QR, VLD, S, PTR, QV.
// STRUCTURE
//  - Shared package mux_pkg: MODE_SEL=0, MODE_RR=1 constants; function clog2_min1 for SW.
//  - Sub-module rr_arb #(N): inputs REQ[N], PTR[SW]; outputs one-hot GNT[N] and index GIDX[SW].
//    Purely combinational rotate-priority encoder, instantiated only when MODE=1.
//  - Top level holds the output register, PTR register, LD/ACK logic and the MODE 0 select decode.
// TESTING
//  1. Reset: assert RST mid-stream with QV=1 -> QV=0, Q=0, ACK=0 at once; first ACK one edge after release.
//  2. MODE 0, N=4, W=8, S=2, VLD=4'b0100, IN[2]=8'hA5, QR=1 -> ACK=4'b0100; next edge Q=A5, QV=1.
//  3. MODE 0 stall: QV=1, Q=8'h11, QR=0 for 3 cycles, S toggled -> Q=11, QV=1, ACK=0 throughout.
//     Then QR=1 with VLD[S] -> new beat loads on that edge, no bubble.
//  4. MODE 0, S=3'd5 with N=5 -> out of range: ACK=0; QV falls to 0 after the held beat drains.
//  5. MODE 1, N=4, VLD=4'b1111, QR=1 for 8 cycles -> grant order 0,1,2,3,0,1,2,3; PTR wraps 3->0.
//  6. MODE 1, VLD=4'b1001, PTR=1 -> grant 3, then 0, then 3. Backpressure with QR=0 for 2 cycles -> grant order unchanged.

Source files
------------

// File: rtl/mux_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : mux_pkg                                                          |
// | Brief   : Shared mode constants and select-width helper for mux_n_stream.  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package mux_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  // Select width never drops below one bit so ports stay legal for tiny N.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_n_stream_rr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : rr_arb                                                           |
// | Brief   : Combinational rotate-priority encoder, scanning upward from ptr. |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module rr_arb
  import mux_pkg::*;
#(
  parameter  int N  = 4,
  localparam int SW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [SW-1:0] gidx
);

  logic w_found;
  int   w_pos;

  always_comb begin
    gnt     = '0;
    gidx    = '0;
    w_found = 1'b0;
    w_pos   = 0;
    for (int k = 0; k < N; k++) begin
      w_pos = (int'(ptr) + k) % N;
      if (!w_found && req[w_pos]) begin
        w_found     = 1'b1;
        gnt[w_pos]  = 1'b1;
        gidx        = SW'(w_pos);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux_n_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mux_n_stream                                                     |
// | Brief   : Registered N:1 stream mux, external select or round-robin.       |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module mux_n_stream
  import mux_pkg::*;
#(
  parameter  int W    = 8,
  parameter  int N    = 4,
  parameter  int MODE = MODE_SEL,
  localparam int SW   = clog2_min1(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in,
  input  logic [N-1:0]   vld,
  output logic [N-1:0]   ack,
  input  logic [SW-1:0]  s,
  output logic [W-1:0]   q,
  output logic           qv,
  input  logic           qr
);

  logic          w_ld;
  logic          w_xfer;
  logic [N-1:0]  w_grant;
  logic [SW-1:0] w_idx;
  logic [W-1:0]  w_din;

  assign w_ld = !qv | qr;

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic [SW-1:0] r_ptr;

      rr_arb #(.N(N)) u_arb (
        .req  (vld),
        .ptr  (r_ptr),
        .gnt  (w_grant),
        .gidx (w_idx)
      );

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_ptr <= '0;
        end else if (w_xfer) begin
          r_ptr <= (int'(w_idx) == N - 1) ? '0 : w_idx + 1'b1;
        end
      end
    end else begin : g_sel
      // Out-of-range selects match no channel, so nothing is granted.
      always_comb begin
        w_grant = '0;
        for (int i = 0; i < N; i++) begin
          w_grant[i] = vld[i] && (int'(s) == i);
        end
      end
      assign w_idx = s;
    end
  endgenerate

  always_comb begin
    w_din = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(w_idx) == i) begin
        w_din = in[i*W +: W];
      end
    end
  end

  assign w_xfer = w_ld & (|w_grant);
  assign ack    = (w_ld && !rst) ? w_grant : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q  <= '0;
      qv <= 1'b0;
    end else if (w_ld) begin
      qv <= w_xfer;
      if (w_xfer) begin
        q <= w_din;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_n_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_mux_n_stream                                                  |
// | Brief   : Self-checking bench: select (N=4, N=5) and round-robin (N=4).    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_mux_n_stream;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] a_in;  logic [3:0] a_vld, a_ack; logic [1:0] a_s; logic [7:0] a_q; logic a_qv, a_qr;
  logic [31:0] b_in;  logic [3:0] b_vld, b_ack; logic [1:0] b_s; logic [7:0] b_q; logic b_qv, b_qr;
  logic [39:0] c_in;  logic [4:0] c_vld, c_ack; logic [2:0] c_s; logic [7:0] c_q; logic c_qv, c_qr;

  mux_n_stream #(.W(8), .N(4), .MODE(0)) u_sel4 (
    .clk(clk), .rst(rst), .in(a_in), .vld(a_vld), .ack(a_ack),
    .s(a_s), .q(a_q), .qv(a_qv), .qr(a_qr));

  mux_n_stream #(.W(8), .N(4), .MODE(1)) u_rr4 (
    .clk(clk), .rst(rst), .in(b_in), .vld(b_vld), .ack(b_ack),
    .s(b_s), .q(b_q), .qv(b_qv), .qr(b_qr));

  mux_n_stream #(.W(8), .N(5), .MODE(0)) u_sel5 (
    .clk(clk), .rst(rst), .in(c_in), .vld(c_vld), .ack(c_ack),
    .s(c_s), .q(c_q), .qv(c_qv), .qr(c_qr));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state per DUT: 0 = sel4, 1 = rr4, 2 = sel5.
  int m_q[3], m_qv[3], m_ptr[3], m_c[3], m_d[3];
  bit m_ld[3];
  logic [3:0] last_b_ack;

  function automatic int pick(input int n, input int mode, input logic [15:0] v,
                              input int sel, input int ptr, input bit ld);
    if (!ld) return -1;
    if (mode == 0) return (sel < n && v[sel]) ? sel : -1;
    for (int k = 0; k < n; k++) begin
      if (v[(ptr + k) % n]) return (ptr + k) % n;
    end
    return -1;
  endfunction

  function automatic logic [31:0] onehot(input int c);
    return (c < 0) ? 32'd0 : (32'd1 << c);
  endfunction

  task automatic pre_edge();
    m_ld[0] = (m_qv[0] == 0) || a_qr;
    m_ld[1] = (m_qv[1] == 0) || b_qr;
    m_ld[2] = (m_qv[2] == 0) || c_qr;
    m_c[0] = pick(4, 0, 16'(a_vld), int'(a_s), m_ptr[0], m_ld[0]);
    m_c[1] = pick(4, 1, 16'(b_vld), int'(b_s), m_ptr[1], m_ld[1]);
    m_c[2] = pick(5, 0, 16'(c_vld), int'(c_s), m_ptr[2], m_ld[2]);
    if (m_c[0] >= 0) m_d[0] = int'(a_in[m_c[0]*8 +: 8]);
    if (m_c[1] >= 0) m_d[1] = int'(b_in[m_c[1]*8 +: 8]);
    if (m_c[2] >= 0) m_d[2] = int'(c_in[m_c[2]*8 +: 8]);
    check("a_ack", 32'(a_ack), onehot(m_c[0]));
    check("b_ack", 32'(b_ack), onehot(m_c[1]));
    check("c_ack", 32'(c_ack), onehot(m_c[2]));
    last_b_ack = b_ack;
  endtask

  task automatic post_edge();
    for (int d = 0; d < 3; d++) begin
      if (m_ld[d]) begin
        if (m_c[d] >= 0) begin
          m_q[d]  = m_d[d];
          m_qv[d] = 1;
          if (d == 1) m_ptr[d] = (m_c[d] + 1) % 4;
        end else begin
          m_qv[d] = 0;
        end
      end
    end
    check("a_q",  32'(a_q),  32'(m_q[0]));  check("a_qv", 32'(a_qv), 32'(m_qv[0]));
    check("b_q",  32'(b_q),  32'(m_q[1]));  check("b_qv", 32'(b_qv), 32'(m_qv[1]));
    check("c_q",  32'(c_q),  32'(m_q[2]));  check("c_qv", 32'(c_qv), 32'(m_qv[2]));
  endtask

  // Inputs are set before calling; ack checked mid-low-phase, outputs after the edge.
  task automatic cycle();
    @(negedge clk); #2;
    pre_edge();
    @(posedge clk); #1;
    post_edge();
  endtask

  // Asynchronous assert mid-cycle, release just after the following edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_a_qv", 32'(a_qv), 0); check("rst_a_q", 32'(a_q), 0); check("rst_a_ack", 32'(a_ack), 0);
    check("rst_b_qv", 32'(b_qv), 0); check("rst_b_q", 32'(b_q), 0); check("rst_b_ack", 32'(b_ack), 0);
    check("rst_c_qv", 32'(c_qv), 0); check("rst_c_q", 32'(c_q), 0); check("rst_c_ack", 32'(c_ack), 0);
    for (int d = 0; d < 3; d++) begin
      m_q[d] = 0; m_qv[d] = 0; m_ptr[d] = 0;
    end
    @(posedge clk); #1;
    check("rst_hold_b_qv", 32'(b_qv), 0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_in = '0; a_vld = '0; a_s = '0; a_qr = 1'b0;
    b_in = '0; b_vld = '0; b_s = '0; b_qr = 1'b0;
    c_in = '0; c_vld = '0; c_s = '0; c_qr = 1'b0;
    for (int d = 0; d < 3; d++) begin
      m_q[d] = 0; m_qv[d] = 0; m_ptr[d] = 0; m_c[d] = -1; m_d[d] = 0; m_ld[d] = 1'b0;
    end
    @(posedge clk); #1;
    check("init_a_qv", 32'(a_qv), 0); check("init_b_q", 32'(b_q), 0); check("init_c_qv", 32'(c_qv), 0);
    rst = 1'b0;

    // Select mode basic transfer.
    a_s = 2'd2; a_vld = 4'b0100; a_in = 32'h00A5_0000; a_qr = 1'b1;
    cycle();
    check("t2_q", 32'(a_q), 32'hA5); check("t2_qv", 32'(a_qv), 1);

    // Stall with select toggling, then consume-and-load in one edge.
    a_s = 2'd1; a_vld = 4'b0010; a_in = 32'h0000_1100;
    cycle();
    check("t3_load", 32'(a_q), 32'h11);
    a_qr = 1'b0;
    repeat (3) begin
      a_s = 2'($urandom); a_vld = 4'($urandom);
      cycle();
      check("t3_stall_q", 32'(a_q), 32'h11); check("t3_stall_qv", 32'(a_qv), 1);
    end
    a_qr = 1'b1; a_s = 2'd3; a_vld = 4'b1000; a_in = 32'h2200_0000;
    cycle();
    check("t3_nobubble_q", 32'(a_q), 32'h22); check("t3_nobubble_qv", 32'(a_qv), 1);
    a_vld = '0;

    // Out-of-range select on the five-channel instance.
    c_in = 40'h44_33_22_11_5A; c_vld = 5'h1F; c_qr = 1'b1; c_s = 3'd0;
    cycle();
    check("t4_q", 32'(c_q), 32'h5A);
    c_s = 3'd5;
    cycle();
    check("t4_oor_qv", 32'(c_qv), 0); check("t4_oor_q", 32'(c_q), 32'h5A);
    c_vld = '0;

    // Round-robin over all-valid, wrapping 3 -> 0.
    b_in = 32'hD3_C2_B1_A0; b_vld = 4'hF; b_qr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("t5_gnt", 32'(last_b_ack), 32'd1 << (i % 4));
    end

    // Sparse request set starting from pointer 1, with backpressure.
    b_vld = 4'b0001;
    cycle();
    b_vld = 4'b1001;
    cycle(); check("t6_gnt3", 32'(last_b_ack), 32'h8);
    b_qr = 1'b0;
    cycle(); check("t6_stall0", 32'(last_b_ack), 0);
    cycle(); check("t6_stall1", 32'(last_b_ack), 0);
    b_qr = 1'b1;
    cycle(); check("t6_gnt0", 32'(last_b_ack), 32'h1);
    cycle(); check("t6_gnt3b", 32'(last_b_ack), 32'h8);

    // Reset mid-stream with a held beat; first grant right after release.
    do_reset();
    cycle(); check("t1_first_gnt", 32'(last_b_ack), 32'h1);

    // Randomized traffic with occasional asynchronous resets.
    repeat (400) begin
      a_in = $urandom; a_vld = 4'($urandom); a_s = 2'($urandom); a_qr = ($urandom_range(0, 3) != 0);
      b_in = $urandom; b_vld = 4'($urandom); b_s = 2'($urandom); b_qr = ($urandom_range(0, 3) != 0);
      c_in = {8'($urandom), $urandom}; c_vld = 5'($urandom); c_s = 3'($urandom);
      c_qr = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) do_reset();
      else cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
